lms_coef_reader: RTL and testbench

//  Reader side of the adaptive FIR coefficient bus. Atomically snapshots all L

---
 rtl/lms_coef_reader_if.sv | 15 +
 rtl/lms_coef_reader.sv | 119 +++++++++++
 tb/tb_lms_coef_reader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lms_coef_reader_if.sv
// Coefficient readout stream: valid/ready handshake carrying one coefficient word,
// its tap index and an end-of-frame flag.
interface lms_coef_reader_if #(
    parameter int CW = 16,
    parameter int IW = 5
) ();
    logic          valid;
    logic          ready;
    logic [CW-1:0] data;
    logic [IW-1:0] index;
    logic          last;

    modport master (output valid, data, index, last, input  ready);
    modport slave  (input  valid, data, index, last, output ready);
endinterface

// File: rtl/lms_coef_reader.sv
// Atomic snapshot and stream-out of the LMS filter coefficients over a valid/ready port.
// Optional trailing checksum word is built when COEF_CHKSUM_EN is defined.
module lms_coef_reader #(
    parameter int L  = 16,
    parameter int CW = 16,
    parameter int IW = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [L*CW-1:0]     coef_flat,
    input  logic                snap_req,
    input  logic [15:0]         auto_period,
    output logic                busy,
    lms_coef_reader_if.master   m,
    output logic [15:0]         snap_count,
    output logic [7:0]          overrun_cnt
);
    localparam int AW = (L > 1) ? $clog2(L) : 1;
`ifdef COEF_CHKSUM_EN
    localparam int LAST = L;
`else
    localparam int LAST = L - 1;
`endif
    localparam logic [IW-1:0] LAST_IDX = IW'(LAST);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state;
    logic [CW-1:0] snap [L];
    logic [15:0]   auto_cnt;
    logic          auto_tick;
    logic          req;
    logic          xfer;
    logic          xfer_last;
    logic          capture;
    logic [IW-1:0] next_idx;
    logic [CW-1:0] next_word;

    // NOTE: auto_tick is decoded from the registered count, so the request is
    // seen in the same cycle the counter sits at auto_period-1.
    assign auto_tick = (auto_period != 16'd0) && (auto_cnt >= auto_period - 16'd1);
    assign req       = snap_req | auto_tick;
    assign xfer      = m.valid & m.ready;
    assign xfer_last = xfer & m.last;
    // A request on the final handshake starts the next frame with no idle gap.
    assign capture   = req & ((state == IDLE) | xfer_last);
    assign next_idx  = m.index + IW'(1);

`ifdef COEF_CHKSUM_EN
    logic [CW-1:0] chk;
    logic [CW-1:0] coef_sum;

    always_comb begin
        coef_sum = '0;
        for (int k = 0; k < L; k++) coef_sum = coef_sum + coef_flat[k*CW +: CW];
    end

    assign next_word = (next_idx == IW'(L)) ? chk : snap[next_idx[AW-1:0]];
`else
    assign next_word = snap[next_idx[AW-1:0]];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            auto_cnt <= 16'd0;
        end else if (auto_period == 16'd0 || auto_tick) begin
            auto_cnt <= 16'd0;
        end else begin
            auto_cnt <= auto_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            m.valid     <= 1'b0;
            m.data      <= '0;
            m.index     <= '0;
            m.last      <= 1'b0;
            snap_count  <= 16'd0;
            overrun_cnt <= 8'd0;
            // NOTE: the snapshot array is reset too, so a read before the first
            // capture is deterministic; this keeps it in flops rather than RAM.
            for (int k = 0; k < L; k++) snap[k] <= '0;
`ifdef COEF_CHKSUM_EN
            chk         <= '0;
`endif
        end else begin
            if (capture) begin
                for (int k = 0; k < L; k++) snap[k] <= coef_flat[k*CW +: CW];
`ifdef COEF_CHKSUM_EN
                chk        <= coef_sum;
`endif
                state      <= STREAM;
                busy       <= 1'b1;
                m.valid    <= 1'b1;
                m.data     <= coef_flat[CW-1:0];
                m.index    <= '0;
                m.last     <= (LAST == 0);
                snap_count <= snap_count + 16'd1;
            end else if (xfer_last) begin
                state   <= IDLE;
                busy    <= 1'b0;
                m.valid <= 1'b0;
                m.last  <= 1'b0;
            end else if (xfer) begin
                m.index <= next_idx;
                m.data  <= next_word;
                m.last  <= (next_idx == LAST_IDX);
            end

            // Requests landing mid-frame are dropped; the snapshot is untouched.
            if (req && state == STREAM && !xfer_last && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_lms_coef_reader.sv
// Directed bench for lms_coef_reader: stream, back-pressure table, overrun,
// back-to-back, auto mode, async reset and (with COEF_CHKSUM_EN) checksum word.
module tb_lms_coef_reader;
    localparam int L  = 16;
    localparam int CW = 16;
    localparam int IW = 5;
`ifdef COEF_CHKSUM_EN
    localparam int FRAME = L + 1;
`else
    localparam int FRAME = L;
`endif

    typedef struct {
        logic          ready;
        logic          exp_valid;
        logic [IW-1:0] exp_index;
        logic [CW-1:0] exp_data;
        logic          exp_last;
    } vec_t;

    logic            clk;
    logic            reset;
    logic [L*CW-1:0] coef_flat;
    logic            snap_req;
    logic [15:0]     auto_period;
    logic            busy;
    logic [15:0]     snap_count;
    logic [7:0]      overrun_cnt;

    int   n_checks;
    int   n_fail;
    vec_t tbl [64];
    int   n_vec;
    int   starts [$];
    int   n_late;

    lms_coef_reader_if #(.CW(CW), .IW(IW)) bus ();

    lms_coef_reader #(.L(L), .CW(CW), .IW(IW)) dut (
        .clk         (clk),
        .reset       (reset),
        .coef_flat   (coef_flat),
        .snap_req    (snap_req),
        .auto_period (auto_period),
        .busy        (busy),
        .m           (bus.master),
        .snap_count  (snap_count),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_coef(input logic [CW-1:0] base);
        for (int k = 0; k < L; k++) coef_flat[k*CW +: CW] = base + CW'(k);
    endtask

    function automatic logic [CW-1:0] exp_word(input logic [CW-1:0] base, input int w);
        logic [CW-1:0] s;
        if (w < L) return base + CW'(w);
        s = '0;
        for (int k = 0; k < L; k++) s = s + base + CW'(k);
        return s;
    endfunction

    task automatic check_word(input string tag, input logic [CW-1:0] base, input int w);
        check({tag, " valid"}, 32'(bus.valid), 32'd1);
        check({tag, " index"}, 32'(bus.index), 32'(w));
        check({tag, " data"},  32'(bus.data),  32'(exp_word(base, w)));
        check({tag, " last"},  32'(bus.last),  32'(w == FRAME - 1));
    endtask

    initial begin
        int w;
        n_checks = 0;
        n_fail   = 0;
        clk = 1'b0; reset = 1'b0; snap_req = 1'b0; auto_period = 16'd0; bus.ready = 1'b0;
        set_coef(16'h0100);

        // Back-pressure vectors: ready pattern 1,0,0 repeating over a 16'h0200-based frame.
        n_vec = 0;
        w = 0;
        while (w < FRAME) begin
            tbl[n_vec].ready     = (n_vec % 3 == 0);
            tbl[n_vec].exp_valid = 1'b1;
            tbl[n_vec].exp_index = IW'(w);
            tbl[n_vec].exp_data  = exp_word(16'h0200, w);
            tbl[n_vec].exp_last  = (w == FRAME - 1);
            if (tbl[n_vec].ready) w++;
            n_vec++;
        end
        tbl[n_vec].ready     = 1'b1;
        tbl[n_vec].exp_valid = 1'b0;
        tbl[n_vec].exp_index = '0;
        tbl[n_vec].exp_data  = '0;
        tbl[n_vec].exp_last  = 1'b0;
        n_vec++;

        // Reset state
        @(negedge clk);
        check("rst busy",    32'(busy),        32'd0);
        check("rst valid",   32'(bus.valid),   32'd0);
        check("rst data",    32'(bus.data),    32'd0);
        check("rst index",   32'(bus.index),   32'd0);
        check("rst last",    32'(bus.last),    32'd0);
        check("rst snapcnt", 32'(snap_count),  32'd0);
        check("rst overrun", 32'(overrun_cnt), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Capture and stream at full rate; coefficients overwritten right after capture
        snap_req  = 1'b1;
        bus.ready = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        for (int k = 0; k < L; k++) coef_flat[k*CW +: CW] = 16'hFFFF;
        check("A busy", 32'(busy), 32'd1);
        for (int i = 0; i < FRAME; i++) begin
            check_word("A", 16'h0100, i);
            @(negedge clk);
        end
`ifdef COEF_CHKSUM_EN
        check("A chk const", 32'(exp_word(16'h0100, L)), 32'h1078);
`endif
        check("A end valid",   32'(bus.valid),  32'd0);
        check("A end busy",    32'(busy),       32'd0);
        check("A end snapcnt", 32'(snap_count), 32'd1);

        // Back-pressure, table-driven
        set_coef(16'h0200);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        for (int i = 0; i < n_vec; i++) begin
            bus.ready = tbl[i].ready;
            check($sformatf("B%0d valid", i), 32'(bus.valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check($sformatf("B%0d index", i), 32'(bus.index), 32'(tbl[i].exp_index));
                check($sformatf("B%0d data", i),  32'(bus.data),  32'(tbl[i].exp_data));
                check($sformatf("B%0d last", i),  32'(bus.last),  32'(tbl[i].exp_last));
            end
            @(negedge clk);
        end
        check("B snapcnt", 32'(snap_count), 32'd2);
        bus.ready = 1'b1;

        // Overrun at word 5, back-to-back request on the final handshake
        set_coef(16'h0300);
        snap_req = 1'b1;
        @(negedge clk);
        set_coef(16'h0400);
        for (int i = 0; i < FRAME; i++) begin
            check_word("C1", 16'h0300, i);
            if (i == 6) check("C overrun", 32'(overrun_cnt), 32'd1);
            snap_req = (i == 5) || (i == FRAME - 1);
            @(negedge clk);
        end
        snap_req = 1'b0;
        check("C b2b snapcnt", 32'(snap_count),  32'd4);
        check("C b2b overrun", 32'(overrun_cnt), 32'd1);
        for (int i = 0; i < FRAME; i++) begin
            check_word("C2", 16'h0400, i);
            @(negedge clk);
        end
        check("C end valid", 32'(bus.valid), 32'd0);

        // Auto mode from a clean reset
        reset = 1'b0;
        @(negedge clk);
        check("D rst snapcnt", 32'(snap_count),  32'd0);
        check("D rst overrun", 32'(overrun_cnt), 32'd0);
        reset = 1'b1;
        set_coef(16'h0100);
        @(negedge clk);
        auto_period = 16'd40;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (bus.valid && bus.index == '0) starts.push_back(c);
        end
        check("D frames", 32'(starts.size()), 32'd5);
        if (starts.size() > 0) check("D first start", 32'(starts[0]), 32'd40);
        for (int i = 1; i < starts.size(); i++)
            check($sformatf("D spacing%0d", i), 32'(starts[i] - starts[i-1]), 32'd40);
        check("D overrun", 32'(overrun_cnt), 32'd0);
        check("D snapcnt", 32'(snap_count),  32'd5);
        auto_period = 16'd0;
        n_late = 0;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (bus.valid && bus.index == '0) n_late++;
        end
        check("D off frames", 32'(n_late),     32'd0);
        check("D off busy",   32'(busy),       32'd0);
        check("D off snapcnt", 32'(snap_count), 32'd5);

        // Asynchronous reset mid-frame at word 7
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        check_word("E", 16'h0100, 7);
        #1 reset = 1'b0;
        #1;
        check("E busy",    32'(busy),        32'd0);
        check("E valid",   32'(bus.valid),   32'd0);
        check("E data",    32'(bus.data),    32'd0);
        check("E index",   32'(bus.index),   32'd0);
        check("E last",    32'(bus.last),    32'd0);
        check("E snapcnt", 32'(snap_count),  32'd0);
        check("E overrun", 32'(overrun_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("E idle valid", 32'(bus.valid), 32'd0);
        check("E idle busy",  32'(busy),      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
